// File: rtl/mantis_synth_pkg.sv
// mantis_synth_pkg
// Shared definitions for the synth voice logic: note-number width, default
// divider width and the allocator FSM state type.
package mantis_synth_pkg;

  localparam int NOTE_W       = 7;
  localparam int DEF_OFFSET_W = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    COMMIT = 2'd2
  } va_state_e;

endpackage

// File: rtl/voice_slot.sv
// voice_slot
// Storage for one tone-divider voice: note number, divider offset, enable and
// a saturating age counter.
// Optional feature macro: VOICE_ALLOC_STEAL_EN (the age output exists only
// when voice stealing is compiled in, since nothing else reads it).
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   all_off     - clears en and age (highest priority)
//   load        - take new_note/new_offset, en=1, age=0
//   clr_en      - clear en, keep offset and note
//   inc_age     - age+1 (saturating) if the voice is active
//   en, note, offset, age - registered voice state
module voice_slot
  import mantis_synth_pkg::*;
#(
  parameter int OFFSET_W = DEF_OFFSET_W,
  parameter int AGE_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                all_off,
  input  logic                load,
  input  logic                clr_en,
  input  logic                inc_age,
  input  logic [NOTE_W-1:0]   new_note,
  input  logic [OFFSET_W-1:0] new_offset,
`ifdef VOICE_ALLOC_STEAL_EN
  output logic [AGE_W-1:0]    age,
`endif
  output logic                en,
  output logic [NOTE_W-1:0]   note,
  output logic [OFFSET_W-1:0] offset
);

  logic                en_q,     en_d;
  logic [NOTE_W-1:0]   note_q,   note_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic [AGE_W-1:0]    age_q,    age_d;

  function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
    if (&a) begin
      return a;
    end else begin
      return a + AGE_W'(1);
    end
  endfunction

  // Next-state for the voice: all_off beats load beats clr_en beats ageing.
  always_comb begin
    en_d     = en_q;
    note_d   = note_q;
    offset_d = offset_q;
    age_d    = age_q;
    if (all_off) begin
      en_d  = 1'b0;
      age_d = '0;
    end else if (load) begin
      en_d     = 1'b1;
      note_d   = new_note;
      offset_d = new_offset;
      age_d    = '0;
    end else if (clr_en) begin
      en_d = 1'b0;
    end else if (inc_age && en_q) begin
      age_d = age_sat_inc(age_q);
    end else begin
      age_d = age_q;
    end
  end

  // Voice state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      note_q   <= '0;
      offset_q <= '0;
      age_q    <= '0;
    end else begin
      en_q     <= en_d;
      note_q   <= note_d;
      offset_q <= offset_d;
      age_q    <= age_d;
    end
  end

  assign en     = en_q;
  assign note   = note_q;
  assign offset = offset_q;
`ifdef VOICE_ALLOC_STEAL_EN
  assign age    = age_q;
`endif

endmodule

// File: rtl/voice_alloc.sv
// voice_alloc
// Allocates note events to NUM_VOICES tone-divider voices. An accepted event
// is scanned against one voice per cycle (SEARCH), then applied in a single
// COMMIT cycle. Note-on precedence: retrigger matching voice, else lowest free
// voice, else steal the oldest voice (VOICE_ALLOC_STEAL_EN) or drop.
// Optional feature macro: VOICE_ALLOC_STEAL_EN (enables stealing).
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   ev_valid/ev_ready     - event handshake (ready only in IDLE)
//   ev_on, ev_note, ev_offset - event payload
//   all_off               - panic: clears all voices, aborts any event
//   voice_offset, voice_en - packed per-voice divider count and enable
//   steal, drop           - one-cycle pulses from the COMMIT edge
// An event offered in the same cycle as all_off is discarded.
module voice_alloc
  import mantis_synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int OFFSET_W   = DEF_OFFSET_W,
  parameter int AGE_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_on,
  input  logic [NOTE_W-1:0]            ev_note,
  input  logic [OFFSET_W-1:0]          ev_offset,
  input  logic                         all_off,
  output logic [NUM_VOICES*OFFSET_W-1:0] voice_offset,
  output logic [NUM_VOICES-1:0]        voice_en,
  output logic                         steal,
  output logic                         drop
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  va_state_e           state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                ready_q, ready_d;
  logic                drop_q, drop_d;
  logic                ev_on_q, ev_on_d;
  logic [NOTE_W-1:0]   ev_note_q, ev_note_d;
  logic [OFFSET_W-1:0] ev_offset_q, ev_offset_d;
  logic                match_found_q, match_found_d;
  logic [IDX_W-1:0]    match_idx_q, match_idx_d;
  logic                free_found_q, free_found_d;
  logic [IDX_W-1:0]    free_idx_q, free_idx_d;
`ifdef VOICE_ALLOC_STEAL_EN
  logic                steal_q, steal_d;
  logic                old_found_q, old_found_d;
  logic [IDX_W-1:0]    old_idx_q, old_idx_d;
  logic [AGE_W-1:0]    old_age_q, old_age_d;
  logic [AGE_W-1:0]    slot_age [NUM_VOICES];
`endif

  logic [NUM_VOICES-1:0] slot_en;
  logic [NOTE_W-1:0]     slot_note   [NUM_VOICES];
  logic [OFFSET_W-1:0]   slot_offset [NUM_VOICES];
  logic [NUM_VOICES-1:0] load_s, clr_s, inc_s;
  logic                  do_load_s;
  logic [IDX_W-1:0]      tgt_s;

  // FSM next state, per-voice scan and commit decision.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    ev_on_d       = ev_on_q;
    ev_note_d     = ev_note_q;
    ev_offset_d   = ev_offset_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    drop_d        = 1'b0;
    clr_s         = '0;
    do_load_s     = 1'b0;
    tgt_s         = '0;
`ifdef VOICE_ALLOC_STEAL_EN
    steal_d       = 1'b0;
    old_found_d   = old_found_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
`endif
    if (all_off) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ev_valid && ready_q) begin
            ev_on_d       = ev_on;
            ev_note_d     = ev_note;
            ev_offset_d   = ev_offset;
            match_found_d = 1'b0;
            free_found_d  = 1'b0;
`ifdef VOICE_ALLOC_STEAL_EN
            old_found_d   = 1'b0;
`endif
            idx_d         = '0;
            state_d       = SEARCH;
          end else begin
            state_d = IDLE;
          end
        end
        SEARCH: begin
          if (slot_en[idx_q]) begin
            if (!match_found_q && (slot_note[idx_q] == ev_note_q)) begin
              match_found_d = 1'b1;
              match_idx_d   = idx_q;
            end else begin
              match_found_d = match_found_q;
            end
`ifdef VOICE_ALLOC_STEAL_EN
            // Strictly-greater keeps the lowest index on age ties.
            if (!old_found_q || (slot_age[idx_q] > old_age_q)) begin
              old_found_d = 1'b1;
              old_idx_d   = idx_q;
              old_age_d   = slot_age[idx_q];
            end else begin
              old_found_d = old_found_q;
            end
`endif
          end else if (!free_found_q) begin
            free_found_d = 1'b1;
            free_idx_d   = idx_q;
          end else begin
            free_found_d = free_found_q;
          end
          if (idx_q == LAST_IDX) begin
            state_d = COMMIT;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        COMMIT: begin
          state_d = IDLE;
          if (ev_on_q) begin
            if (ev_offset_q == '0) begin
              do_load_s = 1'b0;
            end else if (match_found_q) begin
              do_load_s = 1'b1;
              tgt_s     = match_idx_q;
            end else if (free_found_q) begin
              do_load_s = 1'b1;
              tgt_s     = free_idx_q;
            end else begin
`ifdef VOICE_ALLOC_STEAL_EN
              do_load_s = 1'b1;
              tgt_s     = old_idx_q;
              steal_d   = 1'b1;
`else
              drop_d    = 1'b1;
`endif
            end
          end else if (match_found_q) begin
            clr_s[match_idx_q] = 1'b1;
          end else begin
            clr_s = '0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    for (int i = 0; i < NUM_VOICES; i++) begin
      load_s[i] = do_load_s && (tgt_s == IDX_W'(i));
      inc_s[i]  = do_load_s && (tgt_s != IDX_W'(i));
    end
    ready_d = (state_d == IDLE);
  end

  // FSM, latched event and scan-result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      ready_q       <= 1'b1;
      drop_q        <= 1'b0;
      ev_on_q       <= 1'b0;
      ev_note_q     <= '0;
      ev_offset_q   <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
`ifdef VOICE_ALLOC_STEAL_EN
      steal_q       <= 1'b0;
      old_found_q   <= 1'b0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      ready_q       <= ready_d;
      drop_q        <= drop_d;
      ev_on_q       <= ev_on_d;
      ev_note_q     <= ev_note_d;
      ev_offset_q   <= ev_offset_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
`ifdef VOICE_ALLOC_STEAL_EN
      steal_q       <= steal_d;
      old_found_q   <= old_found_d;
      old_idx_q     <= old_idx_d;
      old_age_q     <= old_age_d;
`endif
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
    voice_slot #(
      .OFFSET_W (OFFSET_W),
      .AGE_W    (AGE_W)
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .all_off    (all_off),
      .load       (load_s[g]),
      .clr_en     (clr_s[g]),
      .inc_age    (inc_s[g]),
      .new_note   (ev_note_q),
      .new_offset (ev_offset_q),
`ifdef VOICE_ALLOC_STEAL_EN
      .age        (slot_age[g]),
`endif
      .en         (slot_en[g]),
      .note       (slot_note[g]),
      .offset     (slot_offset[g])
    );
    assign voice_offset[g*OFFSET_W +: OFFSET_W] = slot_offset[g];
  end

  assign voice_en = slot_en;
  assign ev_ready = ready_q;
  assign drop     = drop_q;
`ifdef VOICE_ALLOC_STEAL_EN
  assign steal    = steal_q;
`else
  assign steal    = 1'b0;
`endif

endmodule

// File: tb/tb_voice_alloc.sv
// tb_voice_alloc
// Directed scoreboard bench for voice_alloc (4 voices, 24-bit offsets).
// The driver pushes the hand-computed voice state expected after each event;
// the monitor pops and compares whenever ev_ready rises after an event.
module tb_voice_alloc;

  localparam int NV = 4;
  localparam int OW = 24;
`ifdef VOICE_ALLOC_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif
  // Voice 0 offset once the fifth note-on has been handled.
  localparam int V0_OFF = STEAL ? 5000 : 1000;

  logic              clk;
  logic              rst_n;
  logic              ev_valid;
  logic              ev_ready;
  logic              ev_on;
  logic [6:0]        ev_note;
  logic [OW-1:0]     ev_offset;
  logic              all_off;
  logic [NV*OW-1:0]  voice_offset;
  logic [NV-1:0]     voice_en;
  logic              steal;
  logic              drop;

  voice_alloc #(.NUM_VOICES(NV), .OFFSET_W(OW), .AGE_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_on        (ev_on),
    .ev_note      (ev_note),
    .ev_offset    (ev_offset),
    .all_off      (all_off),
    .voice_offset (voice_offset),
    .voice_en     (voice_en),
    .steal        (steal),
    .drop         (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NV-1:0] en;
    int            off0, off1, off2, off3;
    bit            st;
    bit            dr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   steal_cnt = 0, drop_cnt = 0, exp_st_tot = 0, exp_dr_tot = 0;
  int   busy_cnt = 0;
  logic prev_ready = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [31:0] voff(input int v);
    return 32'(voice_offset[v*OW +: OW]);
  endfunction

  task automatic push_exp(input logic [NV-1:0] en, input int o0, input int o1,
                          input int o2, input int o3, input bit st, input bit dr);
    exp_t e;
    e.en = en; e.off0 = o0; e.off1 = o1; e.off2 = o2; e.off3 = o3;
    e.st = st; e.dr = dr;
    exp_q.push_back(e);
  endtask

  // Monitor: count pulses and busy cycles, compare when an event completes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (steal) steal_cnt++;
      if (drop)  drop_cnt++;
      if (!ev_ready) begin
        busy_cnt++;
      end else if (!prev_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          exp_st_tot += int'(e.st);
          exp_dr_tot += int'(e.dr);
          check("voice_en", 32'(voice_en), 32'(e.en));
          check("offset0", voff(0), e.off0);
          check("offset1", voff(1), e.off1);
          check("offset2", voff(2), e.off2);
          check("offset3", voff(3), e.off3);
          check("steal", 32'(steal), 32'(e.st));
          check("drop", 32'(drop), 32'(e.dr));
          check("steal_count", steal_cnt, exp_st_tot);
          check("drop_count", drop_cnt, exp_dr_tot);
          check("busy_cycles", busy_cnt, NV + 1);
        end
        busy_cnt = 0;
      end else begin
        busy_cnt = 0;
      end
      prev_ready = ev_ready;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ev_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ev_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: ev_ready still 0 after %0d cycles, expected 1", n);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input bit on, input int note, input int off);
    wait_ready();
    ev_valid  = 1'b1;
    ev_on     = on;
    ev_note   = 7'(note);
    ev_offset = OW'(off);
    @(negedge clk);
    ev_valid  = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0; ev_offset = '0; all_off = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready", 32'(ev_ready), 32'd1);
    check("reset_en", 32'(voice_en), 32'd0);
    for (int v = 0; v < NV; v++) check($sformatf("reset_offset%0d", v), voff(v), 32'd0);
    check("reset_steal", 32'(steal), 32'd0);
    check("reset_drop", 32'(drop), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", 32'(ev_ready), 32'd1);

    push_exp(4'b0001, 1000, 0, 0, 0, 1'b0, 1'b0);              send(1'b1, 60, 1000);
    push_exp(4'b0011, 1000, 2000, 0, 0, 1'b0, 1'b0);           send(1'b1, 62, 2000);
    push_exp(4'b0111, 1000, 2000, 3000, 0, 1'b0, 1'b0);        send(1'b1, 64, 3000);
    push_exp(4'b1111, 1000, 2000, 3000, 4000, 1'b0, 1'b0);     send(1'b1, 67, 4000);
    // Fifth note-on: steal oldest (voice 0) or drop.
    push_exp(4'b1111, V0_OFF, 2000, 3000, 4000, STEAL, !STEAL); send(1'b1, 72, 5000);
    push_exp(4'b1101, V0_OFF, 2000, 3000, 4000, 1'b0, 1'b0);   send(1'b0, 62, 9999);
    push_exp(4'b1101, V0_OFF, 2000, 3000, 4000, 1'b0, 1'b0);   send(1'b0, 50, 0);
    push_exp(4'b1101, V0_OFF, 2000, 3000, 4000, 1'b0, 1'b0);   send(1'b1, 80, 0);
    // Retrigger wins over the free voice 1.
    push_exp(4'b1101, V0_OFF, 2000, 777, 4000, 1'b0, 1'b0);    send(1'b1, 64, 777);
    push_exp(4'b1111, V0_OFF, 1234, 777, 4000, 1'b0, 1'b0);    send(1'b1, 90, 1234);

    // all_off lands on the COMMIT edge of note-on 65: no drop/steal, all silent.
    push_exp(4'b0000, V0_OFF, 1234, 777, 4000, 1'b0, 1'b0);
    send(1'b1, 65, 4242);
    repeat (NV) @(negedge clk);
    all_off = 1'b1;
    @(negedge clk);
    all_off = 1'b0;
    check("ready_after_all_off", 32'(ev_ready), 32'd1);
    push_exp(4'b0001, 500, 1234, 777, 4000, 1'b0, 1'b0);       send(1'b1, 60, 500);
    push_exp(4'b0001, 900, 1234, 777, 4000, 1'b0, 1'b0);       send(1'b1, 60, 900);

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 32'd0);
    repeat (3) @(negedge clk);
    check("final_steal_count", steal_cnt, STEAL ? 1 : 0);
    check("final_drop_count", drop_cnt, STEAL ? 0 : 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
